lsu_mem_ctrl: RTL and testbench

- Load/store initiator between the multicycle core's datapath and the byte-addressed data memory.
- Accepts one load or store request at a time and validates size and alignment.
- Drives the memory's addr/wr/rd/size-flag interface and waits out the memory's 2-cycle registered read latency.
- Sign- or zero-extends returned load data and presents the result on a valid/ready response port.

---
 rtl/lsu_mem_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the core datapath and the byte-addressed data memory.
// Define LSU_STATS_EN to build the saturating load/store/error counters; otherwise stat_* read 0.
module lsu_mem_ctrl #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_wr,
    output logic          mem_rd,
    output logic          mem_one_byte,
    output logic          mem_two_bytes,
    output logic          mem_four_bytes,
    input  logic [DW-1:0] mem_data_out,
    output logic [15:0]   stat_loads,
    output logic [15:0]   stat_stores,
    output logic [15:0]   stat_errs
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // ST    | write strobe cycle
    // LD_RD | read strobe cycle
    // LD_W1 | first memory latency cycle
    // LD_W2 | read data valid, captured on exit
    // RESP  | response held until rsp_ready
    typedef enum logic [2:0] {IDLE, ST, LD_RD, LD_W1, LD_W2, RESP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    f3_q, f3_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_in_q, mem_data_in_d;
    logic          mem_wr_q, mem_wr_d;
    logic          mem_rd_q, mem_rd_d;
    logic [2:0]    size_q, size_d;

    logic req_illegal, req_misaligned, req_bad, accept;

    assign req_illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                            (req_store && req_funct3[2]);
    assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_bad        = req_illegal || req_misaligned;
    assign accept         = (state_q == IDLE) && req_valid;

    function automatic logic [2:0] size_flags(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [DW-1:0] extend(input logic [2:0] f3, input logic [DW-1:0] d);
        case (f3)
            3'b000:  return {{(DW-8){d[7]}}, d[7:0]};
            3'b001:  return {{(DW-16){d[15]}}, d[15:0]};
            3'b100:  return {{(DW-8){1'b0}}, d[7:0]};
            3'b101:  return {{(DW-16){1'b0}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        f3_d          = f3_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_wr_d      = mem_wr_q;
        mem_rd_d      = mem_rd_q;
        size_d        = size_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    f3_d        = req_funct3;
                    if (req_bad) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        mem_addr_d = req_addr;
                        size_d     = size_flags(req_funct3[1:0]);
                        if (req_store) begin
                            state_d       = ST;
                            mem_wr_d      = 1'b1;
                            mem_data_in_d = req_wdata;
                        end else begin
                            state_d  = LD_RD;
                            mem_rd_d = 1'b1;
                        end
                    end
                end
            end
            ST: begin
                state_d       = RESP;
                mem_wr_d      = 1'b0;
                mem_addr_d    = '0;
                mem_data_in_d = '0;
                size_d        = '0;
                rsp_valid_d   = 1'b1;
                rsp_err_d     = 1'b0;
                rsp_data_d    = '0;
            end
            LD_RD: begin
                state_d  = LD_W1;
                mem_rd_d = 1'b0;
            end
            LD_W1: state_d = LD_W2;
            LD_W2: begin
                // address and size stay up until here: memory samples flags a cycle after rd
                state_d     = RESP;
                mem_addr_d  = '0;
                size_d      = '0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = extend(f3_q, mem_data_out);
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            f3_q          <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            size_q        <= '0;
        end else begin
            state_q       <= state_d;
            f3_q          <= f3_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_wr_q      <= mem_wr_d;
            mem_rd_q      <= mem_rd_d;
            size_q        <= size_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_err        = rsp_err_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data_in    = mem_data_in_q;
    assign mem_wr         = mem_wr_q;
    assign mem_rd         = mem_rd_q;
    assign mem_one_byte   = size_q[0];
    assign mem_two_bytes  = size_q[1];
    assign mem_four_bytes = size_q[2];

`ifdef LSU_STATS_EN
    logic [15:0] stat_loads_q, stat_loads_d;
    logic [15:0] stat_stores_q, stat_stores_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_errs_d   = stat_errs_q;
        if (accept) begin
            if (req_bad)        stat_errs_d   = sat_inc(stat_errs_q);
            else if (req_store) stat_stores_d = sat_inc(stat_stores_q);
            else                stat_loads_d  = sat_inc(stat_loads_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_errs_q   <= '0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_errs_q   <= stat_errs_d;
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign stat_loads    = '0;
    assign stat_stores   = '0;
    assign stat_errs     = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus random requests against a byte-array model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [15:0] mem_addr;
    logic [31:0] mem_data_in, mem_data_out;
    logic        mem_wr, mem_rd, mem_one_byte, mem_two_bytes, mem_four_bytes;
    logic [15:0] stat_loads, stat_stores, stat_errs;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_loads, exp_stores, exp_errs;
    logic [31:0] last_data;
    logic [7:0]  ref_mem [0:255];

`ifdef LSU_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.AW(16), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_one_byte(mem_one_byte), .mem_two_bytes(mem_two_bytes), .mem_four_bytes(mem_four_bytes),
        .mem_data_out(mem_data_out),
        .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
    );

    // Data memory: writes on the strobe edge, registered read one edge after rd using the held flags.
    logic [7:0] mem_arr [0:255];
    logic       rd_d1 = 1'b0;
    logic       mem_init = 1'b0;
    always @(posedge clk) begin
        int n;
        logic [31:0] r;
        n = mem_four_bytes ? 4 : mem_two_bytes ? 2 : mem_one_byte ? 1 : 0;
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= 8'h00;
            mem_init     <= 1'b1;
            mem_data_out <= '0;
        end else begin
            if (mem_wr)
                for (int i = 0; i < 4; i++)
                    if (i < n) mem_arr[mem_addr[7:0] + 8'(i)] <= mem_data_in[8*i +: 8];
            if (rd_d1) begin
                r = '0;
                for (int i = 0; i < 4; i++)
                    if (i < n) r[8*i +: 8] = mem_arr[mem_addr[7:0] + 8'(i)];
                mem_data_out <= r;
            end
        end
        rd_d1 <= mem_rd;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // Reference behaviour: classify, apply store to ref_mem or build the extended load value.
    task automatic ref_txn(input bit st, input bit [2:0] f3, input bit [15:0] a, input bit [31:0] wd,
                           output bit e, output bit [31:0] d);
        int n;
        bit [31:0] raw;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        e = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3[2]) ||
            (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        d = '0;
        if (!e) begin
            if (st) begin
                for (int i = 0; i < n; i++) ref_mem[a[7:0] + 8'(i)] = wd[8*i +: 8];
            end else begin
                raw = '0;
                for (int i = 0; i < n; i++) raw[8*i +: 8] = ref_mem[a[7:0] + 8'(i)];
                d = raw;
                if (!f3[2] && n < 4 && raw[8*n-1]) d = raw | (32'hFFFF_FFFF << (8*n));
            end
        end
    endtask

    task automatic stat_update(input bit e, input bit st);
        if (STATS_ON) begin
            if (e)       exp_errs   = sat16(exp_errs);
            else if (st) exp_stores = sat16(exp_stores);
            else         exp_loads  = sat16(exp_loads);
        end
    endtask

    task automatic check_stats(input string tag);
        check_val({tag, "_loads"},  32'(stat_loads),  32'(exp_loads));
        check_val({tag, "_stores"}, 32'(stat_stores), 32'(exp_stores));
        check_val({tag, "_errs"},   32'(stat_errs),   32'(exp_errs));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_val({tag, "_rsp"}, 32'({rsp_valid, rsp_err}), 32'd0);
        check_val({tag, "_rsp_data"}, rsp_data, 32'd0);
        check_val({tag, "_mem_ctl"},
                  32'({mem_wr, mem_rd, mem_four_bytes, mem_two_bytes, mem_one_byte}), 32'd0);
        check_val({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_val({tag, "_mem_data_in"}, mem_data_in, 32'd0);
    endtask

    // Starts just after a rising edge with the DUT idle; ends just after the handshake edge.
    task automatic run_txn(input bit st, input bit [2:0] f3, input bit [15:0] a, input bit [31:0] wd);
        bit e;
        bit [31:0] ed;
        bit [2:0] fl_exp;
        int lat_exp, wr_n, rd_n, seen;
        fl_exp = (f3[1:0] == 2'b00) ? 3'b001 : (f3[1:0] == 2'b01) ? 3'b010 : 3'b100;
        ref_txn(st, f3, a, wd, e, ed);
        lat_exp = e ? 0 : (st ? 1 : 3);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wr_n = 0; rd_n = 0; seen = 0; last_data = '0;
        for (int c = 0; c < 8 && seen == 0; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                last_data = rsp_data;
                check_val("rsp_latency", c, lat_exp);
                check_val("rsp_data", rsp_data, ed);
                check_val("rsp_err", 32'(rsp_err), 32'(e));
                check_val("rsp_mem_ctl",
                          32'({mem_wr, mem_rd, mem_four_bytes, mem_two_bytes, mem_one_byte}), 32'd0);
                check_val("rsp_mem_addr", 32'(mem_addr), 32'd0);
                check_val("rsp_mem_data_in", mem_data_in, 32'd0);
            end else begin
                wr_n += 32'(mem_wr);
                rd_n += 32'(mem_rd);
                check_val("size_flags", 32'({mem_four_bytes, mem_two_bytes, mem_one_byte}), 32'(fl_exp));
                check_val("mem_addr", 32'(mem_addr), 32'(a));
                if (mem_wr) check_val("mem_data_in", mem_data_in, wd);
            end
        end
        check_val("rsp_seen", seen, 32'd1);
        check_val("wr_pulses", wr_n, (st && !e) ? 32'd1 : 32'd0);
        check_val("rd_pulses", rd_n, (!st && !e) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        check_val("post_hs_ready", 32'(req_ready), 32'd1);
        check_val("post_hs_valid", 32'(rsp_valid), 32'd0);
        stat_update(e, st);
        check_stats("stat");
    endtask

    task automatic backpressure_test();
        bit e;
        bit [31:0] ed;
        int seen;
        ref_txn(1'b0, 3'b010, 16'h0010, 32'd0, e, ed);
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 16'h0010; req_wdata = '0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 8 && seen == 0; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check_val("bp_rsp_seen", seen, 32'd1);
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 16'h0040; req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_val("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check_val("bp_rsp_data", rsp_data, ed);
            check_val("bp_rsp_err", 32'(rsp_err), 32'd0);
            check_val("bp_req_ready", 32'(req_ready), 32'd0);
            check_val("bp_mem_strobe", 32'({mem_wr, mem_rd}), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("bp_idle_ready", 32'(req_ready), 32'd1);
        check_val("bp_idle_valid", 32'(rsp_valid), 32'd0);
        check_val("bp_idle_wr", 32'(mem_wr), 32'd0);
        @(negedge clk);
        check_val("bp_no_accept_wr", 32'(mem_wr), 32'd0);
        check_val("bp_still_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        stat_update(1'b0, 1'b0);
        check_stats("bp_stat");
    endtask

    task automatic reset_mid_load_test();
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 16'h0010; req_wdata = '0;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
        check_stats("rst_mid_stat");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("rst_hold_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("rst_after_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit        st;
        bit [2:0]  f3;
        bit [15:0] a;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
        rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check_reset_outputs("reset");
        check_stats("reset_stat");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_txn(1'b1, 3'b010, 16'h0010, 32'hDEAD_BEEF);
        run_txn(1'b0, 3'b010, 16'h0010, 32'd0);
        check_val("lw_0x10", last_data, 32'hDEAD_BEEF);
        run_txn(1'b1, 3'b000, 16'h0013, 32'h0000_0080);
        run_txn(1'b0, 3'b000, 16'h0013, 32'd0);
        check_val("lb_0x13", last_data, 32'hFFFF_FF80);
        run_txn(1'b0, 3'b100, 16'h0013, 32'd0);
        check_val("lbu_0x13", last_data, 32'h0000_0080);
        run_txn(1'b1, 3'b001, 16'h0022, 32'h0000_8001);
        run_txn(1'b0, 3'b001, 16'h0022, 32'd0);
        check_val("lh_0x22", last_data, 32'hFFFF_8001);
        run_txn(1'b0, 3'b101, 16'h0022, 32'd0);
        check_val("lhu_0x22", last_data, 32'h0000_8001);
        run_txn(1'b0, 3'b010, 16'h0012, 32'd0);
        run_txn(1'b1, 3'b001, 16'h0021, 32'h0000_BEEF);
        run_txn(1'b0, 3'b011, 16'h0000, 32'd0);
        run_txn(1'b1, 3'b100, 16'h0000, 32'h0000_00AA);

        backpressure_test();
        run_txn(1'b0, 3'b010, 16'h0040, 32'd0);
        check_val("bp_store_ignored", last_data, 32'd0);

        reset_mid_load_test();
        run_txn(1'b0, 3'b010, 16'h0010, 32'd0);

        for (int i = 0; i < 200; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            run_txn(st, f3, a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        check_stats("final_stat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
